// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state and command layout for the ALU command front-end.
package alu_pkg;
  localparam int ALU_N = 8;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_MUL    = 4'b0010;
  localparam logic [3:0] ALU_DIV    = 4'b0011;
  localparam logic [3:0] ALU_AND    = 4'b0100;
  localparam logic [3:0] ALU_OR     = 4'b0101;
  localparam logic [3:0] ALU_XOR    = 4'b0110;
  localparam logic [3:0] ALU_SLL    = 4'b0111;
  localparam logic [3:0] ALU_SRL    = 4'b1000;
  localparam logic [3:0] ALU_OP_MAX = 4'b1000;

  typedef enum logic {IDLE, EXEC} alu_ctrl_state_t;

  // Reference layout at the default width; the top re-declares it for its own N.
  typedef struct packed {
    logic [3:0]       op;
    logic [ALU_N-1:0] a;
    logic [ALU_N-1:0] b;
    logic             sgn;
  } alu_cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push ignored when full, pop ignored when empty.
module alu_cmd_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wptr, r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_push, w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

// File: rtl/alu_cmd_ctrl.sv
// Valid/ready command front-end for a combinational ALU: FIFO -> operand regs -> response reg.
// Optional result/error screening is enabled by defining ALU_CTRL_ERRCHK_EN.
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int N     = ALU_N,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  input  logic         req_signed,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_operation,
  output logic         alu_signed,
  input  logic [N-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_err,
  output logic [15:0]  op_count
);
  typedef struct packed {
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sgn;
  } cmd_t;

  alu_ctrl_state_t r_state, w_state_nxt;
  cmd_t            w_req, w_head;
  logic            w_full, w_empty, w_pop, w_cap, w_rsp_hs;

  assign w_req     = '{op: req_op, a: req_a, b: req_b, sgn: req_signed};
  assign req_ready = !w_full;
  assign w_rsp_hs  = rsp_valid && rsp_ready;

  alu_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (req_valid),
    .i_data (w_req),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // A capture frees the operand regs, so the next command can be popped on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = EXEC;
      end
      EXEC: if (!rsp_valid || rsp_ready) begin
        w_cap = 1'b1;
        if (!w_empty) w_pop = 1'b1;
        else          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_operation <= '0;
      alu_signed    <= 1'b0;
    end else if (w_pop) begin
      alu_a         <= w_head.a;
      alu_b         <= w_head.b;
      alu_operation <= w_head.op;
      alu_signed    <= w_head.sgn;
    end
  end

`ifdef ALU_CTRL_ERRCHK_EN
  logic w_err;
  assign w_err = (alu_operation > ALU_OP_MAX) || ((alu_operation == ALU_DIV) && (alu_b == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rsp_err <= 1'b0;
    else if (w_cap) rsp_err <= w_err;
  end
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
    end else if (w_cap) begin
      rsp_valid  <= 1'b1;
`ifdef ALU_CTRL_ERRCHK_EN
      rsp_result <= w_err ? '0 : alu_result;
`else
      rsp_result <= alu_result;
`endif
    end else if (w_rsp_hs) begin
      rsp_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               op_count <= '0;
    else if (w_rsp_hs && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
  end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: behavioural ALU, directed vector table, corner sequences, random scoreboard.
module tb_alu_cmd_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_signed = 1'b0;
  logic [3:0] req_op = '0, alu_operation;
  logic [7:0] req_a = '0, req_b = '0, alu_a, alu_b, alu_result, rsp_result;
  logic       alu_signed, rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [15:0] op_count;

  int checks = 0, errors = 0;
  int cyc = 0, n_rsp = 0, first_rsp = -1, last_rsp = -1, model_cnt = 0;
  logic hold_prev = 1'b0;
  logic [7:0] last_res = '0;
  logic last_err = 1'b0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_ctrl #(.N(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation), .alu_signed(alu_signed),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .op_count(op_count)
  );

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                       input logic s);
    int q;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * b;
      4'd3: begin
        if (b == 8'd0) return 8'hFF;
        if (s) begin
          q = int'($signed(a)) / int'($signed(b));
          return q[7:0];
        end
        return a / b;
      end
      4'd4: return a & b;
      4'd5: return a | b;
      4'd6: return a ^ b;
      4'd7: return a << b;
      4'd8: return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_operation, alu_a, alu_b, alu_signed);

  // Expected {err, result} for a request.
  function automatic logic [8:0] expect_rsp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                            input logic s);
`ifdef ALU_CTRL_ERRCHK_EN
    if (op > 4'd8 || (op == 4'd3 && b == 8'd0)) return {1'b1, 8'h00};
`endif
    return {1'b0, alu_f(op, a, b, s)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); model_cnt = 0; hold_prev = 1'b0; n_rsp = 0; first_rsp = -1; last_rsp = -1;
  endtask

  // One cycle: drive at negedge, then score the handshakes that the next edge performs.
  task automatic tick(input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic rr, output logic acc);
    logic [8:0] e;
    @(negedge clk);
    cyc++;
    req_valid = v; req_op = op; req_a = a; req_b = b; req_signed = s; rsp_ready = rr;
    if (hold_prev) begin
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_result", 32'(rsp_result), 32'(last_res));
      chk("stall_err", 32'(rsp_err), 32'(last_err));
    end
    acc = v && req_ready;
    if (acc) exp_q.push_back(expect_rsp(op, a, b, s));
    if (rsp_valid && rr) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got result %0h with nothing outstanding", rsp_result);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_result", 32'(rsp_result), 32'(e[7:0]));
        chk("rsp_err", 32'(rsp_err), 32'(e[8]));
      end
      n_rsp++; model_cnt++;
      if (first_rsp < 0) first_rsp = cyc;
      last_rsp = cyc;
    end
    hold_prev = rsp_valid && !rr;
    last_res = rsp_result; last_err = rsp_err;
  endtask

  task automatic drain(input int budget);
    logic acc;
    for (int i = 0; i < budget && (exp_q.size() != 0 || rsp_valid); i++) tick(0, 0, 0, 0, 0, 1, acc);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [3:0] op; logic [7:0] a, b; logic s; logic [7:0] res; logic err;
  } vec_t;
  vec_t vecs[11];

  task automatic run_vec(input vec_t t, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    req_valid = 1'b1; req_op = t.op; req_a = t.a; req_b = t.b; req_signed = t.s; rsp_ready = 1'b0;
    chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({nm, "_lat0"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_lat1"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_alu_op"}, 32'(alu_operation), 32'(t.op));
    @(negedge clk);
    chk({nm, "_lat2"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_result"}, 32'(rsp_result), 32'(t.res));
    chk({nm, "_err"}, 32'(rsp_err), 32'(t.err));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    model_cnt++;
    chk({nm, "_cleared"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_op_count"}, 32'(op_count), 32'(model_cnt));
  endtask

  initial begin
    logic acc;
    int nacc;
`ifdef ALU_CTRL_ERRCHK_EN
    vecs[3]  = '{ALU_DIV, 8'h2A, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{4'b1010, 8'h11, 8'h22, 1'b0, 8'h00, 1'b1};
`else
    vecs[3]  = '{ALU_DIV, 8'h2A, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[4]  = '{4'b1010, 8'h11, 8'h22, 1'b0, 8'h00, 1'b0};
`endif
    vecs[0]  = '{ALU_ADD, 8'd100, 8'd27, 1'b0, 8'd127, 1'b0};
    vecs[1]  = '{ALU_DIV, 8'hF8, 8'h02, 1'b1, 8'hFC, 1'b0};
    vecs[2]  = '{ALU_DIV, 8'hF8, 8'h02, 1'b0, 8'h7C, 1'b0};
    vecs[5]  = '{ALU_SUB, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0};
    vecs[6]  = '{ALU_MUL, 8'd12, 8'd11, 1'b0, 8'h84, 1'b0};
    vecs[7]  = '{ALU_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0};
    vecs[8]  = '{ALU_XOR, 8'hA5, 8'hFF, 1'b0, 8'h5A, 1'b0};
    vecs[9]  = '{ALU_SLL, 8'h01, 8'h03, 1'b0, 8'h08, 1'b0};
    vecs[10] = '{ALU_SRL, 8'h80, 8'h07, 1'b0, 8'h01, 1'b0};

    #1 do_reset();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_alu_ops", 32'({alu_a, alu_b, alu_operation, alu_signed}), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Backpressure: only DEPTH+2 commands fit while responses are stalled.
    do_reset();
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1, ALU_ADD, 8'(i * 17), 8'(i + 3), 0, 0, acc);
      if (acc) nacc++;
    end
    chk("bp_accepted", 32'(nacc), 32'd6);
    tick(0, 0, 0, 0, 0, 0, acc);
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0, acc);
    drain(20);
    chk("bp_rsp_count", 32'(n_rsp), 32'd6);

    // Streaming: one response per cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1, ALU_ADD, 8'($urandom), 8'($urandom), 0, 1, acc);
      chk("strm_accept", 32'(acc), 32'd1);
    end
    drain(20);
    chk("strm_rsp_count", 32'(n_rsp), 32'd8);
    chk("strm_consecutive", 32'(last_rsp - first_rsp), 32'd7);
    tick(0, 0, 0, 0, 0, 1, acc);
    chk("strm_op_count", 32'(op_count), 32'd8);

    // Random traffic against the scoreboard.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] op;
      logic [7:0] b;
      op = ($urandom % 8 == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      b  = ($urandom % 6 == 0) ? 8'h00 : 8'($urandom);
      tick(($urandom % 10) < 7, op, 8'($urandom), b, 1'($urandom), ($urandom % 10) < 6, acc);
    end
    drain(30);
    tick(0, 0, 0, 0, 0, 1, acc);
    chk("rand_op_count", 32'(op_count), 32'(model_cnt));

    // Reset with a held response, a command in EXEC and 3 in the FIFO.
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, ALU_OR, 8'(i), 8'h40, 0, 0, acc);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0, acc);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("mid_req_ready", 32'(req_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_async", 32'({rsp_valid, rsp_err, rsp_result}), 32'd0);
    chk("mid_rst_alu", 32'({alu_a, alu_b, alu_operation, alu_signed}), 32'd0);
    chk("mid_rst_op_count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); hold_prev = 1'b0; n_rsp = 0; model_cnt = 0;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 0, 1, acc);
    chk("mid_no_stale", 32'(n_rsp), 32'd0);
    chk("mid_op_count", 32'(op_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Sequential command front-end for the combinational `alu`. Accepts operation requests on a valid/ready interface and buffers them in a small FIFO. It issues one request at a time to the ALU's operand/operation/signed inputs, captures the ALU result one cycle later, and returns it on a valid/ready response interface with an optional error flag. It sits between the datapath controller and the `alu` instance, and makes the ALU usable as a pipelined, back-pressured functional unit.

## Interface
- `N`, 8: operand/result width; must match the driven `alu`.
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on an edge when `req_valid && req_ready`.
- `req_op` in 4: ALU opcode (0000 add … 1000 srl).
- `req_a`, `req_b` in N: operands.
- `req_signed` in 1: signed arithmetic select.
- `alu_a`, `alu_b` out N: ALU operands, registered.
- `alu_operation` out 4: ALU opcode, registered.
- `alu_signed` out 1: ALU signed select, registered.
- `alu_result` in N: combinational ALU result.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed on an edge when `rsp_valid && rsp_ready`.
- `rsp_result` out N: captured result.
- `rsp_err` out 1: error flag (see Configuration).
- `op_count` out 16: completed responses, saturating at 16'hFFFF.

## Operation
- The request stream enters the FIFO. `req_ready = !fifo_full`, with no combinational path from `rsp_ready`.
- FSM states:
  - IDLE: operand registers are empty.
  - EXEC: operand registers hold a command that is driving the ALU.
- IDLE transitions:
  - FIFO non-empty: pop into the operand registers and go to EXEC.
  - Otherwise: stay in IDLE.
- EXEC capture:
  - A capture occurs when the response register is free, i.e. `!rsp_valid || rsp_ready`.
  - On capture, `alu_result` is written to `rsp_result` and `rsp_valid` is set.
- EXEC next state, in the same edge as the capture:
  - FIFO non-empty: pop the next entry and stay in EXEC.
  - FIFO empty: go to IDLE.
- EXEC with no capture: hold the operand registers unchanged.
- Response register: `rsp_valid` clears on handshake unless it is refilled in the same edge.
- `op_count` increments on each response handshake.
- Simultaneous FIFO push and pop is legal when the FIFO is neither full nor empty. When full, a push is refused through `req_ready = 0`, even if a pop occurs in the same edge.
- FIFO pointers are `$clog2(DEPTH)+1` bits and wrap naturally. Full is when the MSBs differ and the low bits are equal.
- Capacity in flight is DEPTH + 2 (FIFO, operand register, response register).
- Reset values:
  - FIFO: empty.
  - State: IDLE.
  - `alu_a`, `alu_b`, `alu_operation`, `alu_signed`: 0.
  - `rsp_valid`, `rsp_result`, `rsp_err`, `op_count`: 0.
  - `req_ready`: 1.
- Reset asserted mid-operation discards all buffered commands and the pending response. No response is emitted for them.

## Timing
- Latency from request handshake at edge t, with the FIFO empty and the FSM in IDLE:
  - Edge t+1: operands loaded.
  - Edge t+2: result captured.
  - `rsp_valid` is high in the cycle after edge t+2.
- Throughput is one response per cycle while `rsp_ready` is held at 1.
- `rsp_result` and `rsp_err` are stable while `rsp_valid && !rsp_ready`.
- All outputs are registered except `req_ready`, which is decoded from registered pointers.

## Configuration
- `ALU_CTRL_ERRCHK_EN` defined:
  - Error conditions at capture:
    - Opcode > 4'b1000.
    - Opcode 0011 (divide) with `alu_b == 0`.
  - On error: `rsp_err = 1` and `rsp_result = 0`.
  - Otherwise: `rsp_err = 0` and `rsp_result = alu_result`.
- `ALU_CTRL_ERRCHK_EN` undefined:
  - `rsp_err` is tied to 0.
  - `rsp_result = alu_result` unconditionally.

## Structure
- `alu_pkg`:
  - Opcode constants `ALU_ADD`…`ALU_SRL`.
  - `ALU_OP_MAX = 4'b1000`.
  - FSM state typedef `alu_ctrl_state_t` {IDLE, EXEC}.
  - Packed command struct typedef (op, a, b, signed).
- Sub-module `alu_cmd_fifo`: synchronous FIFO, parameterized by width and DEPTH, with push/pop/full/empty.

## Test plan
- Basic add: N=8, IDLE, single request ADD a=100 b=27 unsigned -> `rsp_valid` two edges after accept, `rsp_result = 8'd127`, `rsp_err = 0`, `op_count = 1`.
- Signed divide: DIV a=8'hF8 b=8'h02 signed -> `rsp_result = 8'hFC`; same operands unsigned -> `8'h7C`.
- Error checking: with `ALU_CTRL_ERRCHK_EN`, DIV b=0 -> `rsp_err = 1`, `rsp_result = 0`; opcode 4'b1010 -> `rsp_err = 1`, `rsp_result = 0`. Without the macro -> `rsp_err = 0`.
- Backpressure: `rsp_ready = 0`, 8 requests offered -> exactly 6 accepted, then `req_ready = 0`. Releasing `rsp_ready` yields 6 responses in order, with unchanged values while stalled.
- Streaming: 8 back-to-back ADD requests with `rsp_ready = 1` -> 8 responses on consecutive cycles, `op_count = 8`.
- Reset mid-operation: assert `rsp_ready = 0` and hold `rsp_valid` high with 3 commands buffered, then pulse `rst_n` low -> all outputs at reset values, no stale response after release, `op_count = 0`.
